// File: rtl/countdown_arbiter.sv
// Two-requester round-robin arbiter sharing one WIDTH-bit down counter.
// Optional: define COUNTDOWN_ARBITER_ABORT_EN to let the owner abort a countdown by dropping its request.
module countdown_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] len0,
    input  logic             req1,
    input  logic [WIDTH-1:0] len1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] count,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;   // 0: requester 0 owns the counter
    logic             ptr_q, ptr_d;       // requester favoured on a tie
    logic [WIDTH-1:0] count_q, count_d;

    logic             win;
    logic [WIDTH-1:0] win_len;
    logic             abort;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        win     = (req0 && req1) ? ptr_q : req1;
        win_len = win ? len1 : len0;
        abort   = 1'b0;
`ifdef COUNTDOWN_ARBITER_ABORT_EN
        abort   = owner_q ? !req1 : !req0;
`endif
        case (state_q)
            IDLE: begin
                count_d = '0;
                if (req0 || req1) begin
                    owner_d = win;
                    count_d = win_len;
                    state_d = (win_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    count_d = '0;
                    ptr_d   = ~owner_q;
                end else if (count_q <= WIDTH'(1)) begin
                    // Saturate at zero; the last decrement lands in DONE.
                    state_d = DONE;
                    count_d = '0;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                count_d = '0;
                ptr_d   = ~owner_q;
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            ptr_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // Outputs decode only flopped state, so no input reaches them combinationally.
    assign busy  = (state_q != IDLE);
    assign gnt0  = busy && !owner_q;
    assign gnt1  = busy && owner_q;
    assign done0 = (state_q == DONE) && !owner_q;
    assign done1 = (state_q == DONE) && owner_q;
    assign count = count_q;

endmodule

// File: tb/tb_countdown_arbiter.sv
// Self-checking bench for countdown_arbiter: vector table, corner sequences, random vs. transaction model.
module tb_countdown_arbiter;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0, req1;
    logic [WIDTH-1:0] len0, len1;
    logic             gnt0, gnt1, done0, done1, busy;
    logic [WIDTH-1:0] count;

    int checks = 0;
    int errors = 0;

    countdown_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .len0(len0), .req1(req1), .len1(len1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .count(count), .busy(busy)
    );

    always #5 clk = ~clk;

`ifdef COUNTDOWN_ARBITER_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    typedef struct {
        logic             r0;
        logic [WIDTH-1:0] l0;
        logic             r1;
        logic [WIDTH-1:0] l1;
        logic             g0, g1, d0, d1, b;
        logic [WIDTH-1:0] cnt;
    } vec_t;

    vec_t tbl [15];

    // Transaction-level model: a grant starts a countdown of length n, and
    // everything visible follows from how many edges have passed since then.
    bit m_busy;
    int m_own, m_n, m_age, m_ptr;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input bit g0, input bit g1, input bit d0,
                           input bit d1, input bit b, input int cnt);
        chk({tag, " gnt0"}, int'(gnt0), int'(g0));
        chk({tag, " gnt1"}, int'(gnt1), int'(g1));
        chk({tag, " done0"}, int'(done0), int'(d0));
        chk({tag, " done1"}, int'(done1), int'(d1));
        chk({tag, " busy"}, int'(busy), int'(b));
        chk({tag, " count"}, int'(count), cnt);
    endtask

    task automatic model_edge(input bit r0, input bit r1, input int l0, input int l1, input bit rs);
        if (rs) begin
            m_busy = 0; m_ptr = 0;
        end else if (!m_busy) begin
            if (r0 || r1) begin
                m_own  = (r0 && r1) ? m_ptr : (r1 ? 1 : 0);
                m_n    = (m_own == 1) ? l1 : l0;
                m_age  = 0;
                m_busy = 1;
            end
        end else if (ABORT && m_age < m_n && !((m_own == 1) ? r1 : r0)) begin
            m_busy = 0; m_ptr = 1 - m_own;
        end else begin
            m_age++;
            if (m_age > m_n) begin
                m_busy = 0; m_ptr = 1 - m_own;
            end
        end
    endtask

    task automatic step();
        bit r0, r1, rs;
        int l0, l1;
        r0 = req0; r1 = req1; l0 = int'(len0); l1 = int'(len1); rs = rst;
        @(posedge clk);
        model_edge(r0, r1, l0, l1, rs);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        step();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; req0 = 0; req1 = 0; len0 = '0; len1 = '0;
        m_busy = 0; m_ptr = 0; m_own = 0; m_n = 0; m_age = 0;
        #2 rst = 1'b1;
        #1 chk_all("por", 0, 0, 0, 0, 0, 0);

        //          r0 l0 r1 l1  g0 g1 d0 d1 b cnt
        tbl[0]  = '{1, 2, 1, 3,  1, 0, 0, 0, 1, 2};
        tbl[1]  = '{1, 2, 1, 3,  1, 0, 0, 0, 1, 1};
        tbl[2]  = '{1, 2, 1, 3,  1, 0, 1, 0, 1, 0};
        tbl[3]  = '{1, 2, 1, 3,  0, 0, 0, 0, 0, 0};
        tbl[4]  = '{1, 2, 1, 3,  0, 1, 0, 0, 1, 3};
        tbl[5]  = '{1, 2, 1, 3,  0, 1, 0, 0, 1, 2};
        tbl[6]  = '{1, 2, 1, 3,  0, 1, 0, 0, 1, 1};
        tbl[7]  = '{1, 2, 1, 3,  0, 1, 0, 1, 1, 0};
        tbl[8]  = '{1, 2, 1, 3,  0, 0, 0, 0, 0, 0};
        tbl[9]  = '{1, 2, 1, 3,  1, 0, 0, 0, 1, 2};
        tbl[10] = '{1, 2, 1, 3,  1, 0, 0, 0, 1, 1};
        tbl[11] = '{1, 2, 1, 3,  1, 0, 1, 0, 1, 0};
        tbl[12] = '{0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
        tbl[13] = '{0, 0, 1, 0,  0, 1, 0, 1, 1, 0};
        tbl[14] = '{0, 0, 0, 0,  0, 0, 0, 0, 0, 0};

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            req0 = tbl[i].r0; len0 = tbl[i].l0; req1 = tbl[i].r1; len1 = tbl[i].l1;
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].g0, tbl[i].g1, tbl[i].d0, tbl[i].d1,
                    tbl[i].b, int'(tbl[i].cnt));
        end

        // Maximum length: 15 RUN cycles, no wrap.
        req0 = 1; len0 = 4'd15;
        step();
        chk_all("max grant", 1, 0, 0, 0, 1, 15);
        for (int i = 1; i <= 15; i++) begin
            step();
            chk_all($sformatf("max t%0d", i), 1, 0, i == 15, 0, 1, 15 - i);
        end
        step();
        chk_all("max idle", 0, 0, 0, 0, 0, 0);

        // Owner drops its request at count=3.
        len0 = 4'd6;
        step();
        chk("ab grant", int'(count), 6);
        step(); step(); step();
        chk("ab at3", int'(count), 3);
        req0 = 0;
        step();
        if (ABORT) begin
            chk_all("ab abort", 0, 0, 0, 0, 0, 0);
        end else begin
            chk_all("ab c2", 1, 0, 0, 0, 1, 2);
            step();
            chk_all("ab c1", 1, 0, 0, 0, 1, 1);
            step();
            chk_all("ab done", 1, 0, 1, 0, 1, 0);
            step();
            chk_all("ab idle", 0, 0, 0, 0, 0, 0);
        end

        // Move the pointer to requester 1, then reset mid-run.
        req0 = 1; len0 = 4'd1;
        step(); step(); step();
        chk_all("rs pre", 0, 0, 0, 0, 0, 0);
        req0 = 0; req1 = 1; len1 = 4'd4;
        step(); step(); step();
        chk_all("rs at2", 0, 1, 0, 0, 1, 2);
        #3 rst = 1'b1;
        #1 chk_all("rs async", 0, 0, 0, 0, 0, 0);
        step();
        chk_all("rs held", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        req0 = 1; req1 = 1; len0 = 4'd1; len1 = 4'd1;
        step();
        chk_all("rs ptr0", 1, 0, 0, 0, 1, 1);
        req0 = 0; req1 = 0;
        if (!ABORT) begin
            step(); step();
        end else begin
            step();
        end
        do_reset();

        // Random traffic against the model.
        m_busy = 0; m_ptr = 0;
        for (int c = 0; c < 3000; c++) begin
            req0 = ($urandom_range(0, 3) != 0);
            req1 = ($urandom_range(0, 3) != 0);
            len0 = WIDTH'($urandom_range(0, 15));
            len1 = WIDTH'($urandom_range(0, 15));
            if (c % 8 == 0) begin
                len0 = WIDTH'($urandom_range(0, 2));
                len1 = WIDTH'($urandom_range(0, 2));
            end
            step();
            chk_all($sformatf("rnd%0d", c), m_busy && m_own == 0, m_busy && m_own == 1,
                    m_busy && m_own == 0 && m_age == m_n, m_busy && m_own == 1 && m_age == m_n,
                    m_busy, m_busy ? (m_n - m_age) : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
